fp_comp: RTL and testbench



---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_comp_if.sv | 15 +
 rtl/fp_classify.sv | 23 ++
 rtl/fp_comp.sv | 78 +++++++
 tb/tb_fp_comp.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 field layout and compare-outcome encoding for the fp_comp block.
package fp_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  // Bit 1 is geq, bit 0 is leq, so the enum value drives the flags directly.
  typedef enum logic [1:0] {
    CMP_UNORD   = 2'b00,
    CMP_LESS    = 2'b01,
    CMP_GREATER = 2'b10,
    CMP_EQUAL   = 2'b11
  } cmp_e;

endpackage

// File: rtl/fp_comp_if.sv
// Operand/result bundle for fp_comp. There is no handshake: every clock edge
// samples one operand pair, and the flags for it are valid one edge later.
interface fp_comp_if
  import fp_pkg::*;
  ();

  logic [FP_W-1:0] dataa;
  logic [FP_W-1:0] datab;
  logic            geq;
  logic            leq;

  modport master (output dataa, output datab, input geq, input leq);
  modport slave  (input dataa, input datab, output geq, output leq);

endinterface

// File: rtl/fp_classify.sv
// Splits one binary32 word into its class flags, sign and 31-bit magnitude.
module fp_classify
  import fp_pkg::*;
  (
    input  logic [FP_W-1:0] word,
    output logic            is_zero,
    output logic            is_nan,
    output logic            is_inf,
    output logic            sign,
    output logic [FP_W-2:0] mag
  );

  fp_t f;

  assign f       = word;
  assign is_zero = (f.exp == '0) && (f.man == '0);
  assign is_nan  = (f.exp == EXP_MAX) && (f.man != '0);
  assign is_inf  = (f.exp == EXP_MAX) && (f.man == '0);
  assign sign    = f.sign;
  // Exponent above mantissa makes the raw bits order like the magnitude, denormals included.
  assign mag     = {f.exp, f.man};

endmodule

// File: rtl/fp_comp.sv
// Registered three-way binary32 compare: {geq,leq} = 11 equal, 10 greater,
// 01 less, 00 unordered.
module fp_comp
  import fp_pkg::*;
  (
    input  logic      clk,
    input  logic      reset,
    fp_comp_if.slave  bus
  );

  logic            a_zero, a_nan, a_inf, a_sign;
  logic            b_zero, b_nan, b_inf, b_sign;
  logic [FP_W-2:0] a_mag, b_mag;

  logic mag_gt;
  logic mag_eq;
  cmp_e cmp;
  cmp_e res_q;

  fp_classify u_class_a (
    .word    (bus.dataa),
    .is_zero (a_zero),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .sign    (a_sign),
    .mag     (a_mag)
  );

  fp_classify u_class_b (
    .word    (bus.datab),
    .is_zero (b_zero),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .sign    (b_sign),
    .mag     (b_mag)
  );

  // Infinity wins any magnitude contest except against another infinity.
  always_comb begin
    mag_eq = (a_mag == b_mag);
    mag_gt = 1'b0;
    if (a_inf) begin
      mag_gt = !b_inf;
    end else if (!b_inf) begin
      mag_gt = (a_mag > b_mag);
    end
  end

  always_comb begin
    cmp = CMP_UNORD;
    if (a_nan || b_nan) begin
      cmp = CMP_UNORD;
    end else if (a_zero && b_zero) begin
      cmp = CMP_EQUAL;
    end else if (a_sign != b_sign) begin
      cmp = a_sign ? CMP_LESS : CMP_GREATER;
    end else if (mag_eq) begin
      cmp = CMP_EQUAL;
    end else if (mag_gt ^ a_sign) begin
      // Negative operands invert the magnitude ordering.
      cmp = CMP_GREATER;
    end else begin
      cmp = CMP_LESS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= CMP_UNORD;
    end else begin
      res_q <= cmp;
    end
  end

  assign bus.geq = res_q[1];
  assign bus.leq = res_q[0];

endmodule

// File: tb/tb_fp_comp.sv
// Self-checking bench for fp_comp: directed cases, reset/latency checks and
// random operands against a real-arithmetic reference model.
module tb_fp_comp;

  logic clk;
  logic reset;

  fp_comp_if bus ();

  fp_comp u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic real pow2(int k);
    real p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic bit is_nan_word(logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  function automatic real to_real(logic [31:0] w);
    int  e;
    real m;
    real r;
    e = int'(w[30:23]);
    m = w[22:0];
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = m * pow2(-149);
    else             r = (m + 8388608.0) * pow2(e - 150);
    return w[31] ? -r : r;
  endfunction

  function automatic logic [1:0] ref_cmp(logic [31:0] a, logic [31:0] b);
    real ra, rb;
    if (is_nan_word(a) || is_nan_word(b)) return 2'b00;
    ra = to_real(a);
    rb = to_real(b);
    return {ra >= rb, ra <= rb};
  endfunction

  // driver / checker tasks
  task automatic check(string tag, logic [1:0] expected);
    logic [1:0] observed;
    observed = {bus.geq, bus.leq};
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed {geq,leq}=%b expected %b (a=%h b=%h)",
             tag, observed, expected, bus.dataa, bus.datab);
    end
  endtask

  // Drive on the falling edge, then check just after the next rising edge.
  task automatic step(string tag, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    bus.dataa = a;
    bus.datab = b;
    exp_q.push_back(ref_cmp(a, b));
    @(posedge clk);
    #1;
    check(tag, exp_q.pop_front());
  endtask

  logic [31:0] dir_a[19];
  logic [31:0] dir_b[19];
  logic [31:0] specials[8];

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  prev;

    dir_a = '{32'h80000000, 32'h3FC00000, 32'h3FCCCCCD, 32'h3FC00000, 32'h40200000,
              32'h3FC00000, 32'h3FC00000, 32'hBFC00000, 32'hBFC00000, 32'hBFCCCCCD,
              32'h7FC00000, 32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h00000001,
              32'h00000000, 32'hFF800000, 32'h7F800000, 32'h007FFFFF};
    dir_b = '{32'h00000000, 32'h3FC00000, 32'h3FC00000, 32'h3FCCCCCD, 32'h3FC00000,
              32'h40200000, 32'hBFC00000, 32'h3FC00000, 32'hBFCCCCCD, 32'hBFC00000,
              32'h3FC00000, 32'h7FC00000, 32'h7F7FFFFF, 32'hFF800000, 32'h00000000,
              32'h80000001, 32'hFF7FFFFF, 32'h7F800000, 32'h00800000};
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'hFF800001, 32'h00000001, 32'h7F7FFFFF};

    // reset
    reset     = 1'b1;
    bus.dataa = 32'h3FC00000;
    bus.datab = 32'h3FC00000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 2'b00);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 2'b11);

    // directed cases
    for (int i = 0; i < 19; i++) begin
      step($sformatf("directed_%0d", i), dir_a[i], dir_b[i]);
    end

    // reset overrides an equal compare, then the compare returns
    @(negedge clk);
    reset     = 1'b1;
    bus.dataa = 32'h3FC00000;
    bus.datab = 32'h3FC00000;
    @(posedge clk);
    #1;
    check("reset_override", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_equal", 2'b11);

    // back-to-back operands: output must not move before the edge
    prev = 2'b11;
    for (int i = 0; i < 40; i++) begin
      ra = dir_a[$urandom_range(0, 18)];
      rb = dir_b[$urandom_range(0, 18)];
      @(negedge clk);
      bus.dataa = ra;
      bus.datab = rb;
      #1;
      check("hold_before_edge", prev);
      prev = ref_cmp(ra, rb);
      @(posedge clk);
      #1;
      check("one_cycle_lag", prev);
    end

    // random operands, biased toward equal, near-equal and special values
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        2:       rb = {~ra[31], ra[30:0]};
        3:       begin ra = specials[$urandom_range(0, 7)]; rb = specials[$urandom_range(0, 7)]; end
        4:       begin ra[30:23] = 8'd0; rb = {$urandom_range(0, 1) == 1, 8'd0, 23'($urandom)}; end
        default: rb = $urandom;
      endcase
      step("random", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
